// File: rtl/sha3_avmm_regbank_pkg.sv
// Shared definitions for the SHA3 Avalon-MM register bank.
//  - FSM state type
//  - CTRL / STATUS bit positions
//  - word offsets of the control registers, derived from the message/digest sizes
//  - byte-lane write merge helper
package sha3_regs_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_IE    = 1;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_TOUT = 2;
  localparam int unsigned ST_ERR  = 3;

  // Control registers follow the MSG and DIGEST windows back to back.
  function automatic int unsigned ctrl_addr(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out;
  endfunction

  function automatic int unsigned status_addr(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out + 1;
  endfunction

  function automatic int unsigned rc_lo_addr(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out + 2;
  endfunction

  function automatic int unsigned rc_hi_addr(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out + 3;
  endfunction

  function automatic int unsigned cycles_addr(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out + 4;
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sha3_avmm_regbank_if.sv
// Avalon-MM slave bus bundle for the SHA3 register bank.
//  master : drives address/write/writedata/byteenable/read, receives readdata
//  slave  : the register bank side
interface sha3_avmm_regbank_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/sha3_avmm_regbank_cycle_timer.sv
// sha3_cycle_timer: 32-bit saturating cycle counter with synchronous clear
// and a timeout flag.
//  clk, rst_n : clock, asynchronous active-low reset
//  clr        : zero the count (has priority over en)
//  en         : count this cycle
//  count      : current count, sticks at 2**32-1
//  expired    : count has reached TIMEOUT
module sha3_cycle_timer #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] count,
  output logic        expired
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

  assign expired = (count >= TIMEOUT);

endmodule

// File: rtl/sha3_avmm_regbank.sv
// sha3_avmm_regbank: Avalon-MM register bank in front of the SHA3 core.
//  clk_clk, reset_reset_n : clock, asynchronous active-low reset
//  avs                    : Avalon-MM slave (read latency 1)
//  core_msg               : N_IN message words, word 0 at [31:0]
//  core_round_const       : {RC_HI, RC_LO}
//  core_start             : one-cycle start pulse to the core
//  core_done, core_digest : completion pulse and digest from the core
//  irq                    : IE & (DONE | TOUT)
// Word map: MSG[0..N_IN-1], DIGEST[N_IN..N_IN+N_OUT-1], CTRL, STATUS, RC_LO,
// RC_HI, CYCLES; everything else reads 0 and ignores writes.
module sha3_avmm_regbank
  import sha3_regs_pkg::*;
#(
  parameter int unsigned N_IN    = 8,
  parameter int unsigned N_OUT   = 8,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  sha3_avmm_regbank_if.slave    avs,
  output logic [N_IN*32-1:0]    core_msg,
  output logic [63:0]           core_round_const,
  output logic                  core_start,
  input  logic                  core_done,
  input  logic [N_OUT*32-1:0]   core_digest,
  output logic                  irq
);

  localparam int unsigned A_CTRL   = ctrl_addr(N_IN, N_OUT);
  localparam int unsigned A_STATUS = status_addr(N_IN, N_OUT);
  localparam int unsigned A_RC_LO  = rc_lo_addr(N_IN, N_OUT);
  localparam int unsigned A_RC_HI  = rc_hi_addr(N_IN, N_OUT);
  localparam int unsigned A_CYCLES = cycles_addr(N_IN, N_OUT);

  state_e               state;
  logic                 ie, done, tout, err;
  logic [N_OUT*32-1:0]  digest_q;

  logic [ADDR_W-1:0]    addr;
  logic [31:0]          addr_u;
  logic [31:0]          wdata;
  logic [3:0]           be;
  logic                 busy;
  logic                 wr_msg, wr_ctrl, wr_status, wr_rc_lo, wr_rc_hi;
  logic                 start_bit, start_req, drop_err;
  logic [31:0]          rd_mux;

  logic [31:0]          cycles;
  logic                 expired;
  logic                 tmr_en;

  assign addr   = avs.avs_address;
  assign addr_u = 32'(addr);
  assign wdata  = avs.avs_writedata;
  assign be     = avs.avs_byteenable;
  assign busy   = (state == RUN);

  assign wr_msg    = avs.avs_write && (addr_u < N_IN);
  assign wr_ctrl   = avs.avs_write && (addr_u == A_CTRL);
  assign wr_status = avs.avs_write && (addr_u == A_STATUS);
  assign wr_rc_lo  = avs.avs_write && (addr_u == A_RC_LO);
  assign wr_rc_hi  = avs.avs_write && (addr_u == A_RC_HI);

  assign start_bit = wr_ctrl && be[0] && wdata[CTRL_START];
  assign start_req = start_bit && !busy;
  // Anything that would disturb the core's inputs mid-run is refused and flagged.
  assign drop_err  = busy && (wr_msg || wr_rc_lo || wr_rc_hi || start_bit);

  // Counting stops on the cycle that ends the run so CYCLES freezes at its final value.
  assign tmr_en = busy && !core_done && !expired;

  sha3_cycle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .clr     (start_req),
    .en      (tmr_en),
    .count   (cycles),
    .expired (expired)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state            <= IDLE;
      core_start       <= 1'b0;
      core_msg         <= '0;
      core_round_const <= '0;
      digest_q         <= '0;
      ie               <= 1'b0;
      done             <= 1'b0;
      tout             <= 1'b0;
      err              <= 1'b0;
    end else begin
      core_start <= 1'b0;

      if (!busy) begin
        for (int unsigned i = 0; i < N_IN; i++) begin
          if (wr_msg && (addr_u == i))
            core_msg[i*32 +: 32] <= be_merge(core_msg[i*32 +: 32], wdata, be);
        end
        if (wr_rc_lo) core_round_const[31:0]  <= be_merge(core_round_const[31:0], wdata, be);
        if (wr_rc_hi) core_round_const[63:32] <= be_merge(core_round_const[63:32], wdata, be);
      end

      if (wr_ctrl && be[0]) ie <= wdata[CTRL_IE];

      // W1C first; the set paths below are later in the block so a
      // same-cycle hardware set overrides the software clear.
      if (wr_status && be[0]) begin
        if (wdata[ST_DONE]) done <= 1'b0;
        if (wdata[ST_TOUT]) tout <= 1'b0;
        if (wdata[ST_ERR])  err  <= 1'b0;
      end

      if (drop_err) err <= 1'b1;

      case (state)
        IDLE: begin
          if (start_req) begin
            state      <= RUN;
            core_start <= 1'b1;
            done       <= 1'b0;
            tout       <= 1'b0;
          end
        end
        RUN: begin
          if (core_done) begin
            digest_q <= core_digest;
            done     <= 1'b1;
            state    <= IDLE;
          end else if (expired) begin
            tout  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (addr_u == i) rd_mux = core_msg[i*32 +: 32];
    end
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (addr_u == N_IN + i) rd_mux = digest_q[i*32 +: 32];
    end
    if (addr_u == A_CTRL)   rd_mux[CTRL_IE] = ie;
    if (addr_u == A_STATUS) begin
      rd_mux[ST_BUSY] = busy;
      rd_mux[ST_DONE] = done;
      rd_mux[ST_TOUT] = tout;
      rd_mux[ST_ERR]  = err;
    end
    if (addr_u == A_RC_LO)  rd_mux = core_round_const[31:0];
    if (addr_u == A_RC_HI)  rd_mux = core_round_const[63:32];
    if (addr_u == A_CYCLES) rd_mux = cycles;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.avs_readdata <= '0;
    end else if (avs.avs_read) begin
      avs.avs_readdata <= rd_mux;
    end
  end

  assign irq = ie & (done | tout);

endmodule
